mem_regfile: RTL and testbench

MEM_REGFILE -- requirements
Module: mem_regfile

---
 rtl/mem_regfile.sv | 172 +++++++++++++++++
 tb/tb_mem_regfile.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_regfile.sv
// mem_regfile: register-file memory with two registered read ports.
//
// Storage: DEPTH writable entries of WIDTH bits. There is one write port.
// There are two independent read ports (A and B), each with a latency of one
// cycle. The write port bypasses to both read ports.
//
// Read address decode:
//   - addr < DEPTH  : storage entry
//   - addr == DEPTH : const_a input, sampled at the read edge and not stored
//   - addr == DEPTH+1 : const_c input, sampled at the read edge and not stored
//   - any other address : all zeros, still qualified by rd_valid
//
// A clr_start pulse in IDLE starts a bulk clear. The clear zeroes one entry per
// cycle for DEPTH cycles. During the clear, ready is low and all requests are
// ignored.
//
// Ports:
//   clk, rst              : rising-edge clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data : write request
//   rd_en_a/rd_addr_a     : read request, port A
//   rd_en_b/rd_addr_b     : read request, port B
//   const_a/const_c       : read-only constants at addresses DEPTH / DEPTH+1
//   clr_start             : one-cycle bulk-clear request
//   ready                 : high in IDLE; requests are accepted only then
//   rd_data_a/rd_data_b   : registered read data; holds when no read is served
//   rd_valid_a/rd_valid_b : read data qualifier
module mem_regfile #(
  parameter int WIDTH = 89,
  parameter int DEPTH = 64,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    rd_addr_b,
  input  logic [WIDTH-1:0] const_a,
  input  logic [WIDTH-1:0] const_c,
  input  logic             clr_start,
  output logic             ready,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid_a,
  output logic             rd_valid_b
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] ADDR_CA    = AW'(DEPTH);
  localparam logic [AW-1:0] ADDR_CC    = AW'(DEPTH + 1);
  localparam logic [IW-1:0] LAST_ENTRY = IW'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IW-1:0]    clr_cnt;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_ok;
  logic             rd_ok_a;
  logic             rd_ok_b;
  logic [WIDTH-1:0] rd_word_a;
  logic [WIDTH-1:0] rd_word_b;

  // Returns 1 when the address selects a writable storage entry.
  function automatic logic in_storage(input logic [AW-1:0] addr);
    return addr < ADDR_CA;
  endfunction

  // Read-port decode. A same-cycle accepted write to the same address wins
  // over the stored value, so each port sees the freshest data.
  function automatic logic [WIDTH-1:0] decode_read(
    input logic [AW-1:0]    addr,
    input logic [WIDTH-1:0] entry,
    input logic [WIDTH-1:0] ca,
    input logic [WIDTH-1:0] cc,
    input logic             byp,
    input logic [WIDTH-1:0] byp_data
  );
    logic [WIDTH-1:0] word;
    word = '0;
    if (in_storage(addr)) begin
      word = byp ? byp_data : entry;
    end else if (addr == ADDR_CA) begin
      word = ca;
    end else if (addr == ADDR_CC) begin
      word = cc;
    end
    return word;
  endfunction

  assign ready = (state == IDLE);

  // clr_start wins over a same-cycle write. Reads are still served in that
  // cycle, from the pre-clear contents.
  assign wr_ok   = ready && wr_en && !clr_start && in_storage(wr_addr);
  assign rd_ok_a = ready && rd_en_a;
  assign rd_ok_b = ready && rd_en_b;

  always_comb begin
    rd_word_a = decode_read(rd_addr_a, mem[rd_addr_a[IW-1:0]], const_a, const_c,
                            wr_ok && (wr_addr == rd_addr_a), wr_data);
    rd_word_b = decode_read(rd_addr_b, mem[rd_addr_b[IW-1:0]], const_a, const_c,
                            wr_ok && (wr_addr == rd_addr_b), wr_data);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_start) state_nxt = CLEAR;
      CLEAR:   if (clr_cnt == LAST_ENTRY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear sweep counter. It is parked at zero outside CLEAR, so each clear
  // starts from entry 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= (clr_cnt == LAST_ENTRY) ? '0 : clr_cnt + 1'b1;
    end else begin
      clr_cnt <= '0;
    end
  end

  // Storage update: the clear sweep or an accepted write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr[IW-1:0]] <= wr_data;
    end
  end

  // Read output registers: valid follows the request, data holds when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_a <= 1'b0;
      rd_valid_b <= 1'b0;
      rd_data_a  <= '0;
      rd_data_b  <= '0;
    end else begin
      rd_valid_a <= rd_ok_a;
      rd_valid_b <= rd_ok_b;
      if (rd_ok_a) rd_data_a <= rd_word_a;
      if (rd_ok_b) rd_data_b <= rd_word_b;
    end
  end

endmodule

// File: tb/tb_mem_regfile.sv
// Testbench for mem_regfile.
//
// Stimulus pushes the expected read data, tagged with the cycle in which it is
// due, into a per-port queue. A monitor on the falling edge pops and compares
// the queue whenever an entry is due. In every other cycle the monitor
// requires rd_valid to be low.
module tb_mem_regfile;

  localparam int W  = 89;
  localparam int AW = 7;
  localparam int D  = 64;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          rd_en_a;
  logic [AW-1:0] rd_addr_a;
  logic          rd_en_b;
  logic [AW-1:0] rd_addr_b;
  logic [W-1:0]  const_a;
  logic [W-1:0]  const_c;
  logic          clr_start;
  logic          ready;
  logic [W-1:0]  rd_data_a;
  logic [W-1:0]  rd_data_b;
  logic          rd_valid_a;
  logic          rd_valid_b;

  typedef struct {
    int           due;
    logic [W-1:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc      = 0;
  int   n_assert = 0;
  int   n_fail   = 0;

  mem_regfile #(.WIDTH(W), .DEPTH(D), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en_a   (rd_en_a),
    .rd_addr_a (rd_addr_a),
    .rd_en_b   (rd_en_b),
    .rd_addr_b (rd_addr_b),
    .const_a   (const_a),
    .const_c   (const_c),
    .clr_start (clr_start),
    .ready     (ready),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rd_valid_a(rd_valid_a),
    .rd_valid_b(rd_valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor for both read ports
  always @(negedge clk) begin
    n_assert++;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      if (rd_valid_a !== 1'b1 || rd_data_a !== qa[0].data) begin
        n_fail++;
        $display("FAIL rd_a cyc %0d: valid=%0b data=%h, required valid=1 data=%h",
                 cyc, rd_valid_a, rd_data_a, qa[0].data);
      end
      void'(qa.pop_front());
    end else if (rd_valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_a_novalid cyc %0d: valid=%0b, required 0", cyc, rd_valid_a);
    end
    n_assert++;
    if (qb.size() > 0 && qb[0].due == cyc) begin
      if (rd_valid_b !== 1'b1 || rd_data_b !== qb[0].data) begin
        n_fail++;
        $display("FAIL rd_b cyc %0d: valid=%0b data=%h, required valid=1 data=%h",
                 cyc, rd_valid_b, rd_data_b, qb[0].data);
      end
      void'(qb.pop_front());
    end else if (rd_valid_b !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_b_novalid cyc %0d: valid=%0b, required 0", cyc, rd_valid_b);
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en     = 1'b0;
    rd_en_a   = 1'b0;
    rd_en_b   = 1'b0;
    clr_start = 1'b0;
  endtask

  task automatic read_a(input int addr, input logic [W-1:0] exp_data);
    exp_t e;
    rd_en_a   = 1'b1;
    rd_addr_a = AW'(addr);
    e.due     = cyc + 1;
    e.data    = exp_data;
    qa.push_back(e);
  endtask

  task automatic read_b(input int addr, input logic [W-1:0] exp_data);
    exp_t e;
    rd_en_b   = 1'b1;
    rd_addr_b = AW'(addr);
    e.due     = cyc + 1;
    e.data    = exp_data;
    qb.push_back(e);
  endtask

  task automatic write(input int addr, input logic [W-1:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
  endtask

  initial begin
    int cnt;
    rst       = 1'b1;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    const_a   = '0;
    const_c   = '0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_data_a", rd_data_a, '0);
    check("reset_rd_data_b", rd_data_b, '0);
    check("reset_rd_valid_a", W'(rd_valid_a), '0);
    check("reset_rd_valid_b", W'(rd_valid_b), '0);
    check("reset_ready", W'(ready), W'(1));
    rst = 1'b0;
    tick();

    // Write, then read the same entry on the next cycle
    write(5, 89'h1_2345);
    tick();
    idle();
    read_a(5, 89'h1_2345);
    read_b(5, 89'h1_2345);
    tick();
    idle();
    tick();

    // Same-cycle bypass, seen by both ports
    write(9, 89'hAA);
    read_b(9, 89'hAA);
    read_a(9, 89'hAA);
    tick();
    idle();
    tick();

    // Constant addresses and out-of-range addresses
    const_a = 89'h77;
    const_c = 89'h99;
    read_a(64, 89'h77);
    read_b(65, 89'h99);
    tick();
    idle();
    write(64, 89'h55);
    tick();
    idle();
    read_a(64, 89'h77);
    read_b(100, 89'h0);
    tick();
    idle();
    tick();

    // Fill every entry with its index plus one
    for (int i = 0; i < D; i++) begin
      write(i, W'(i + 1));
      tick();
    end
    idle();
    read_a(0, 89'd1);
    read_b(63, 89'd64);
    tick();
    idle();

    // Start a clear. The same-cycle write is dropped, but the read is still
    // served from the pre-clear contents.
    clr_start = 1'b1;
    write(3, 89'hDEAD);
    read_a(3, 89'd4);
    tick();
    check("clear_entered_ready", W'(ready), '0);
    // Requests during CLEAR must be ignored (no push: valid must stay low).
    write(7, 89'h5);
    rd_en_a   = 1'b1;
    rd_addr_a = 7'd3;
    rd_en_b   = 1'b1;
    rd_addr_b = 7'd9;
    cnt = 0;
    while (ready === 1'b0 && cnt < 200) begin
      cnt++;
      tick();
    end
    idle();
    check("clear_busy_cycles", W'(cnt), W'(64));
    for (int i = 0; i < D; i++) begin
      read_a(i, 89'h0);
      read_b(D - 1 - i, 89'h0);
      tick();
    end
    idle();
    tick();

    // Reset in the middle of a clear
    for (int i = 0; i < 4; i++) begin
      write(i, W'(32'hF0 + i));
      tick();
    end
    idle();
    read_b(2, 89'hF2);
    tick();
    idle();
    clr_start = 1'b1;
    read_a(0, 89'hF0);
    tick();
    idle();
    repeat (19) tick();
    check("midclear_ready_low", W'(ready), '0);
    rst = 1'b1;
    #1;
    check("rst_rd_data_a", rd_data_a, '0);
    check("rst_rd_data_b", rd_data_b, '0);
    check("rst_rd_valid_a", W'(rd_valid_a), '0);
    check("rst_ready", W'(ready), W'(1));
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ready", W'(ready), W'(1));
    for (int i = 0; i < D; i++) begin
      read_a(i, 89'h0);
      read_b(i, 89'h0);
      tick();
    end
    idle();
    repeat (2) tick();
    check("queue_a_drained", W'(qa.size()), '0);
    check("queue_b_drained", W'(qb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
